aes_cipher_ctrl: RTL and testbench
==================================

AES_CIPHER_CTRL -- requirements
Module: aes_cipher_ctrl

Interface
REQ-001 Parameter: none; round counts are fixed constants.
REQ-002 clk_i  in  1  clock; single clock domain; all state updates on the rising edge.
REQ-003 rst_ni  in  1  asynchronous active-low reset.
REQ-004 in_valid_i  in  1  new block present on the datapath input.
REQ-005 in_ready_o  out  1  controller accepts a block this cycle.
REQ-006 op_i  in  1  cipher direction: CIPH_FWD=0, CIPH_INV=1.
REQ-007 key_len_i  in  3  one-hot key length: AES_128=001, AES_192=010, AES_256=100.
REQ-008 clear_i  in  1  request to wipe the state register.
REQ-009 out_valid_o  out  1  result is held on the datapath output.
REQ-010 out_ready_i  in  1  consumer accepts the result.
REQ-011 op_o  out  1  latched direction; drives the shift-rows, sub-bytes and mix-columns op inputs.
REQ-012 state_sel_o  out  2  state mux select: STATE_INIT=0, STATE_ROUND=1, STATE_CLEAR=2.
REQ-013 add_rk_sel_o  out  2  add-round-key select: ADD_RK_INIT=0, ADD_RK_ROUND=1, ADD_RK_FINAL=2.
REQ-014 state_we_o  out  1  state register write enable.
REQ-015 round_o  out  4  current round index, 0..14.
REQ-016 key_len_err_o  out  1  one-cycle pulse when an accepted key_len_i is not one-hot.

Function
REQ-017 The FSM SHALL have exactly five states: IDLE, INIT, ROUND, FINISH, CLEAR.
REQ-018 Nr SHALL be 10, 12 or 14 for AES_128, AES_192 or AES_256; a non-one-hot key_len_i SHALL use Nr=10 and pulse key_len_err_o once.
REQ-019 IDLE: in_ready_o=1; in_valid_i=1 SHALL latch op_i and Nr, set round to 0, and go to INIT.
REQ-020 IDLE with clear_i=1 and in_valid_i=0: go to CLEAR; if both are 1, the block start SHALL win.
REQ-021 INIT (one cycle): state_sel=STATE_INIT, add_rk_sel=ADD_RK_INIT, state_we=1; round becomes 1; go to ROUND.
REQ-022 ROUND: state_sel=STATE_ROUND, add_rk_sel=ADD_RK_ROUND, state_we=1; round increments each cycle; at round==Nr-1 go to FINISH with round=Nr.
REQ-023 FINISH: out_valid_o=1, state_sel=STATE_ROUND, add_rk_sel=ADD_RK_FINAL; state_we SHALL equal out_ready_i; on out_ready_i=1 go to IDLE with round=0.
REQ-024 While out_ready_i=0 in FINISH, all outputs SHALL hold stable (backpressure without limit).
REQ-025 CLEAR (one cycle): state_sel=STATE_CLEAR, state_we=1, in_ready_o=0; then go to IDLE.
REQ-026 in_ready_o SHALL be 0 in every state except IDLE; no new block is accepted in the same cycle as the output handshake.
REQ-027 Latency: accept at cycle 0 gives out_valid_o at cycle Nr+1 (11, 13 or 15).
REQ-028 Changes of op_i or key_len_i after acceptance SHALL have no effect; clear_i outside IDLE SHALL be ignored and not stored.
REQ-029 In all states other than those above, state_we_o, out_valid_o and key_len_err_o SHALL be 0 and selects SHALL default to 0.

Reset
REQ-030 Asynchronous assertion SHALL force IDLE, round_o=0, op_o=CIPH_FWD, Nr=10 and all strobes to 0; deassertion SHALL be synchronous to clk_i.
REQ-031 Reset in the middle of an operation SHALL abort it with no out_valid_o; the first accept after release SHALL behave as a fresh start.

Structure
REQ-032 ciph_op_e, state_sel_e, add_rk_sel_e, key_len_e and the Nr constants SHALL live in the shared aes_pkg.
REQ-033 The block SHALL have no sub-modules; the round counter and FSM are inline, and the FSM state SHALL be an enum typedef local to the module.

Verification
REQ-034 AES_128 fwd, accept at cycle 0, out_ready_i=1 -> round_o 1..9 at cycles 2..10, out_valid_o=1 at cycle 11, add_rk_sel_o=2 at that cycle, and state_we_o asserted 11 times in total.
REQ-035 AES_256 inv, out_ready_i held at 0 for 5 cycles -> out_valid_o rises at cycle 15, outputs stay stable until ready, op_o=1 throughout, then return to IDLE.
REQ-036 key_len_i=011 -> key_len_err_o pulses once and out_valid_o=1 at cycle 11.
REQ-037 clear_i=1 in IDLE -> one cycle with state_sel_o=2 and state_we_o=1; clear_i=1 during ROUND -> no effect.
REQ-038 rst_ni low at round 5 of an AES_192 operation -> immediate IDLE and round_o=0; the next AES_128 block completes at cycle 11.
REQ-039 in_valid_i=1 and clear_i=1 together in IDLE -> INIT is taken and no CLEAR cycle occurs.

Source files
------------

// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES datapath types and round-count constants.
//   ciph_op_e     : cipher direction (forward / inverse)
//   state_sel_e   : state register input mux select
//   add_rk_sel_e  : add-round-key input select
//   key_len_e     : one-hot key length encoding
//   NR_*          : number of rounds per key length
//   nr_for_key_len / key_len_is_valid : key length decode helpers
// -----------------------------------------------------------------------------
package aes_pkg;

  typedef enum logic {
    CIPH_FWD = 1'b0,
    CIPH_INV = 1'b1
  } ciph_op_e;

  typedef enum logic [1:0] {
    STATE_INIT  = 2'd0,
    STATE_ROUND = 2'd1,
    STATE_CLEAR = 2'd2
  } state_sel_e;

  typedef enum logic [1:0] {
    ADD_RK_INIT  = 2'd0,
    ADD_RK_ROUND = 2'd1,
    ADD_RK_FINAL = 2'd2
  } add_rk_sel_e;

  typedef enum logic [2:0] {
    AES_128 = 3'b001,
    AES_192 = 3'b010,
    AES_256 = 3'b100
  } key_len_e;

  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  // A malformed (non-one-hot) key length falls back to the AES-128 round count.
  function automatic logic [3:0] nr_for_key_len(input logic [2:0] key_len);
    logic [3:0] nr;
    case (key_len)
      AES_128: nr = NR_128;
      AES_192: nr = NR_192;
      AES_256: nr = NR_256;
      default: nr = NR_128;
    endcase
    return nr;
  endfunction

  function automatic logic key_len_is_valid(input logic [2:0] key_len);
    logic ok;
    case (key_len)
      AES_128, AES_192, AES_256: ok = 1'b1;
      default:                   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/aes_cipher_ctrl.sv
// -----------------------------------------------------------------------------
// aes_cipher_ctrl
// Round controller for an iterative AES cipher core. Sequences one initial
// add-round-key, Nr-1 full rounds and a final round whose result is held
// until the consumer takes it.
//
// Ports
//   clk_i, rst_ni     : clock, asynchronous active-low reset
//   in_valid_i        : new block present on the datapath input
//   in_ready_o        : block accepted this cycle (IDLE only)
//   op_i              : cipher direction, latched on accept
//   key_len_i         : one-hot key length, latched on accept
//   clear_i           : wipe the state register (honoured in IDLE only)
//   out_valid_o       : result held on the datapath output
//   out_ready_i       : consumer accepts the result
//   op_o              : latched direction for shift-rows/sub-bytes/mix-columns
//   state_sel_o       : state register input mux select
//   add_rk_sel_o      : add-round-key select
//   state_we_o        : state register write enable
//   round_o           : current round index 0..14
//   key_len_err_o     : one-cycle pulse after accepting a non-one-hot key_len_i
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready_o depends only on the FSM state; out_valid_o stays high and
// every output stays stable until out_ready_i is seen high.
//
// Reset assertion is asynchronous; release must be synchronised to clk_i by
// the reset generator.
// -----------------------------------------------------------------------------
module aes_cipher_ctrl
  import aes_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic       op_i,
  input  logic [2:0] key_len_i,
  input  logic       clear_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic       op_o,
  output logic [1:0] state_sel_o,
  output logic [1:0] add_rk_sel_o,
  output logic       state_we_o,
  output logic [3:0] round_o,
  output logic       key_len_err_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    ROUND  = 3'd2,
    FINISH = 3'd3,
    CLEAR  = 3'd4
  } fsm_e;

  fsm_e        fsm_q,     fsm_d;
  logic [3:0]  round_q,   round_d;
  logic [3:0]  nr_q,      nr_d;
  ciph_op_e    op_q,      op_d;
  logic        key_err_q, key_err_d;

  state_sel_e  state_sel;
  add_rk_sel_e add_rk_sel;
  logic        in_ready;
  logic        out_valid;
  logic        state_we;

  always_comb begin
    fsm_d      = fsm_q;
    round_d    = round_q;
    nr_d       = nr_q;
    op_d       = op_q;
    key_err_d  = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    state_we   = 1'b0;
    state_sel  = STATE_INIT;
    add_rk_sel = ADD_RK_INIT;

    unique case (fsm_q)
      IDLE: begin
        in_ready = 1'b1;
        // A block start takes priority over a simultaneous clear request.
        if (in_valid_i) begin
          op_d      = ciph_op_e'(op_i);
          nr_d      = nr_for_key_len(key_len_i);
          key_err_d = ~key_len_is_valid(key_len_i);
          round_d   = 4'd0;
          fsm_d     = INIT;
        end else if (clear_i) begin
          fsm_d = CLEAR;
        end
      end

      INIT: begin
        state_sel  = STATE_INIT;
        add_rk_sel = ADD_RK_INIT;
        state_we   = 1'b1;
        round_d    = 4'd1;
        fsm_d      = ROUND;
      end

      ROUND: begin
        state_sel  = STATE_ROUND;
        add_rk_sel = ADD_RK_ROUND;
        state_we   = 1'b1;
        round_d    = round_q + 4'd1;
        // The last full round is Nr-1; the counter then reads Nr in FINISH.
        if (round_q == nr_q - 4'd1) begin
          fsm_d = FINISH;
        end
      end

      FINISH: begin
        out_valid  = 1'b1;
        state_sel  = STATE_ROUND;
        add_rk_sel = ADD_RK_FINAL;
        // The final round result is written only when it is consumed, so the
        // held output stays unchanged under backpressure.
        state_we   = out_ready_i;
        if (out_ready_i) begin
          round_d = 4'd0;
          fsm_d   = IDLE;
        end
      end

      CLEAR: begin
        state_sel = STATE_CLEAR;
        state_we  = 1'b1;
        fsm_d     = IDLE;
      end

      default: begin
        fsm_d   = IDLE;
        round_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fsm_q     <= IDLE;
      round_q   <= 4'd0;
      nr_q      <= NR_128;
      op_q      <= CIPH_FWD;
      key_err_q <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      round_q   <= round_d;
      nr_q      <= nr_d;
      op_q      <= op_d;
      key_err_q <= key_err_d;
    end
  end

  assign in_ready_o    = in_ready;
  assign out_valid_o   = out_valid;
  assign state_we_o    = state_we;
  assign state_sel_o   = state_sel;
  assign add_rk_sel_o  = add_rk_sel;
  assign op_o          = op_q;
  assign round_o       = round_q;
  assign key_len_err_o = key_err_q;

endmodule

// File: tb/tb_aes_cipher_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aes_cipher_ctrl
// Directed and randomised block sequences for aes_cipher_ctrl. Expected
// values come from a transaction-level view of the controller: a block with
// Nr rounds shows round index c-1 on cycle c (c >= 2), the result appears on
// cycle Nr+1 and the state register is written Nr+1 times per block.
// -----------------------------------------------------------------------------
module tb_aes_cipher_ctrl;

  logic       clk;
  logic       rst_n;
  logic       in_valid_i;
  logic       in_ready_o;
  logic       op_i;
  logic [2:0] key_len_i;
  logic       clear_i;
  logic       out_valid_o;
  logic       out_ready_i;
  logic       op_o;
  logic [1:0] state_sel_o;
  logic [1:0] add_rk_sel_o;
  logic       state_we_o;
  logic [3:0] round_o;
  logic       key_len_err_o;

  int checks   = 0;
  int failures = 0;

  aes_cipher_ctrl dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .op_i          (op_i),
    .key_len_i     (key_len_i),
    .clear_i       (clear_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .op_o          (op_o),
    .state_sel_o   (state_sel_o),
    .add_rk_sel_o  (add_rk_sel_o),
    .state_we_o    (state_we_o),
    .round_o       (round_o),
    .key_len_err_o (key_len_err_o)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Round count from the key length: one-hot bit i selects 10 + 2*i rounds,
  // anything else is treated as AES-128.
  function automatic int ref_nr(input logic [2:0] kl);
    int nr;
    nr = 10;
    if ($countones(kl) == 1) begin
      for (int i = 0; i < 3; i++) begin
        if (kl[i]) nr = 10 + 2 * i;
      end
    end
    return nr;
  endfunction

  function automatic bit ref_key_err(input logic [2:0] kl);
    return ($countones(kl) != 1);
  endfunction

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_in_ready"},  in_ready_o,    1);
    chk({tag, "_out_valid"}, out_valid_o,   0);
    chk({tag, "_we"},        state_we_o,    0);
    chk({tag, "_round"},     round_o,       0);
    chk({tag, "_key_err"},   key_len_err_o, 0);
  endtask

  // ---------------- driver ----------------
  // Runs one full block starting from IDLE at a negedge. stall is the number
  // of FINISH cycles with out_ready_i low before the consumer accepts.
  task automatic run_block(input logic [2:0] kl, input logic op, input int stall,
                           input bit clr_at_accept, input bit clr_in_round);
    int nr;
    int we_cnt;
    int clr_cycle;
    nr        = ref_nr(kl);
    we_cnt    = 0;
    clr_cycle = $urandom_range(2, nr);

    // cycle 0: accept
    in_valid_i  = 1'b1;
    key_len_i   = kl;
    op_i        = op;
    clear_i     = clr_at_accept;
    out_ready_i = 1'($urandom_range(0, 1));
    #1;
    chk("acc_in_ready", in_ready_o, 1);
    chk("acc_out_valid", out_valid_o, 0);

    // cycle 1: initial add-round-key, inputs scrambled to show they are ignored
    @(negedge clk);
    in_valid_i = 1'b0;
    clear_i    = 1'b0;
    op_i       = ~op;
    key_len_i  = 3'($urandom);
    #1;
    chk("init_sel",     state_sel_o,   0);
    chk("init_add_rk",  add_rk_sel_o,  0);
    chk("init_we",      state_we_o,    1);
    chk("init_round",   round_o,       0);
    chk("init_key_err", key_len_err_o, ref_key_err(kl));
    chk("init_ready",   in_ready_o,    0);
    chk("init_op",      op_o,          op);
    we_cnt += int'(state_we_o);

    // cycles 2..Nr: full rounds
    for (int c = 2; c <= nr; c++) begin
      @(negedge clk);
      clear_i   = clr_in_round && (c == clr_cycle);
      op_i      = 1'($urandom);
      key_len_i = 3'($urandom);
      #1;
      chk("rnd_round",     round_o,       32'(c - 1));
      chk("rnd_sel",       state_sel_o,   1);
      chk("rnd_add_rk",    add_rk_sel_o,  1);
      chk("rnd_we",        state_we_o,    1);
      chk("rnd_out_valid", out_valid_o,   0);
      chk("rnd_key_err",   key_len_err_o, 0);
      chk("rnd_ready",     in_ready_o,    0);
      chk("rnd_op",        op_o,          op);
      we_cnt += int'(state_we_o);
    end

    // cycle Nr+1 onward: result held until out_ready_i
    @(negedge clk);
    clear_i = 1'b0;
    for (int s = 0; s <= stall; s++) begin
      if (s != 0) @(negedge clk);
      out_ready_i = (s == stall);
      #1;
      chk("fin_out_valid", out_valid_o,  1);
      chk("fin_round",     round_o,      32'(nr));
      chk("fin_sel",       state_sel_o,  1);
      chk("fin_add_rk",    add_rk_sel_o, 2);
      chk("fin_we",        state_we_o,   (s == stall));
      chk("fin_ready",     in_ready_o,   0);
      chk("fin_op",        op_o,         op);
      we_cnt += int'(state_we_o);
    end

    // back in IDLE
    @(negedge clk);
    out_ready_i = 1'b0;
    #1;
    chk_idle("post");
    chk("we_total", 32'(we_cnt), 32'(nr + 1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n       = 1'b0;
    in_valid_i  = 1'b0;
    op_i        = 1'b0;
    key_len_i   = 3'b001;
    clear_i     = 1'b0;
    out_ready_i = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    chk_idle("reset");
    chk("reset_op", op_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // AES-128 forward, consumer ready
    run_block(3'b001, 1'b0, 0, 1'b0, 1'b0);
    // AES-256 inverse, five cycles of backpressure
    run_block(3'b100, 1'b1, 5, 1'b0, 1'b0);
    // malformed key length falls back to 10 rounds
    run_block(3'b011, 1'b0, 0, 1'b0, 1'b0);

    // clear request in IDLE: exactly one clear cycle
    @(negedge clk);
    clear_i = 1'b1;
    #1;
    chk("clr_idle_ready", in_ready_o, 1);
    @(negedge clk);
    clear_i = 1'b0;
    #1;
    chk("clr_sel",       state_sel_o, 2);
    chk("clr_we",        state_we_o,  1);
    chk("clr_ready",     in_ready_o,  0);
    chk("clr_out_valid", out_valid_o, 0);
    @(negedge clk);
    #1;
    chk_idle("clr_after");

    // clear during ROUND is ignored
    @(negedge clk);
    run_block(3'b001, 1'b1, 1, 1'b0, 1'b1);
    // block start wins over a simultaneous clear
    run_block(3'b010, 1'b1, int'($urandom_range(0, 3)), 1'b1, 1'b0);

    // reset in the middle of an AES-192 block at round 5
    @(negedge clk);
    in_valid_i = 1'b1;
    key_len_i  = 3'b010;
    op_i       = 1'b1;
    @(negedge clk);
    in_valid_i = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    chk("mid_round", round_o, 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("mid_rst");
    chk("mid_rst_op", op_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_idle("rst_release");
    run_block(3'b001, 1'b0, 0, 1'b0, 1'b0);

    // randomised blocks
    for (int n = 0; n < 8; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_block(3'($urandom), 1'($urandom), int'($urandom_range(0, 4)),
                1'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
